// File: rtl/cordic_seq_pkg.sv
// Shared types and constants for the iterative CORDIC sequencer.
// The x start value is derived from FRAC_W so the gain pre-compensation follows the fixed-point format.
package cordic_seq_pkg;

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  localparam int ANGLE_W     = 10;
  localparam int Z_W         = 11;
  localparam int K_W         = 5;
  localparam int ANGLE_LIMIT = 99;

  // round(0.607253 * 2^frac_w); 14 fractional bits gives 9949
  function automatic int x_init_round(input int frac_w);
    return $rtoi(0.607253 * (2.0 ** frac_w) + 0.5);
  endfunction

  function automatic logic out_of_range(input logic signed [ANGLE_W-1:0] angle);
    return (int'(angle) > ANGLE_LIMIT) || (int'(angle) < -ANGLE_LIMIT);
  endfunction

endpackage

// File: rtl/cordic_seq_if.sv
// Angle-in / result-out handshake plus the side-band arctangent LUT lookup.
interface cordic_seq_if
  import cordic_seq_pkg::*;
#(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ANGLE_W-1:0] angle_in;
  logic                     abort;
  logic [K_W-1:0]           lut_k;
  logic [ANGLE_W-1:0]       lut_angle;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] cos_out;
  logic signed [DATA_W-1:0] sin_out;
  logic signed [Z_W-1:0]    z_res;
  logic                     range_err;

  modport slave (
    input  in_valid, angle_in, abort, lut_angle, out_ready,
    output in_ready, lut_k, out_valid, cos_out, sin_out, z_res, range_err
  );

  modport master (
    output in_valid, angle_in, abort, lut_angle, out_ready,
    input  in_ready, lut_k, out_valid, cos_out, sin_out, z_res, range_err
  );
endinterface

// File: rtl/cordic_seq_stage.sv
// One CORDIC micro-rotation: rotate (x, y) towards the residual angle z by atan(2^-k).
module cordic_seq_stage
  import cordic_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [Z_W-1:0]    z,
  input  logic [K_W-1:0]           k,
  input  logic [ANGLE_W-1:0]       lut_angle,
  output logic signed [DATA_W-1:0] x_next,
  output logic signed [DATA_W-1:0] y_next,
  output logic signed [Z_W-1:0]    z_next
);
  logic signed [DATA_W-1:0] x_sh;
  logic signed [DATA_W-1:0] y_sh;
  logic signed [Z_W-1:0]    step;
  logic                     z_neg;

  assign x_sh  = x >>> k;
  assign y_sh  = y >>> k;
  assign step  = signed'({1'b0, lut_angle});
  assign z_neg = z[Z_W-1];

  // d = +1 when z >= 0, otherwise -1; sums wrap at DATA_W
  assign x_next = z_neg ? (x + y_sh) : (x - y_sh);
  assign y_next = z_neg ? (y - x_sh) : (y + x_sh);
  assign z_next = z_neg ? (z + step) : (z - step);
endmodule

// File: rtl/cordic_seq.sv
// Rotation-mode CORDIC sequencer: one micro-rotation per clock, LUT indexed by lut_k.
module cordic_seq
  import cordic_seq_pkg::*;
#(
  parameter int                       ITERATIONS = 20,
  parameter int                       DATA_W     = 16,
  parameter int                       FRAC_W     = 14,
  parameter logic signed [DATA_W-1:0] X_INIT     = DATA_W'(x_init_round(FRAC_W))
) (
  input logic          clk,
  input logic          rst,
  cordic_seq_if.slave  bus
);
  localparam logic [K_W-1:0] LAST_K = K_W'(ITERATIONS - 1);

  state_t                   state_reg, state_next;
  logic [K_W-1:0]           k_reg, k_next;
  logic signed [DATA_W-1:0] x_reg, x_next, y_reg, y_next;
  logic signed [Z_W-1:0]    z_reg, z_next;
  logic                     err_reg, err_next;

  logic signed [DATA_W-1:0] x_rot, y_rot;
  logic signed [Z_W-1:0]    z_rot;

  cordic_seq_stage #(.DATA_W(DATA_W)) u_stage (
    .x         (x_reg),
    .y         (y_reg),
    .z         (z_reg),
    .k         (k_reg),
    .lut_angle (bus.lut_angle),
    .x_next    (x_rot),
    .y_next    (y_rot),
    .z_next    (z_rot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      z_reg     <= z_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    z_next     = z_reg;
    err_next   = err_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          x_next     = X_INIT;
          y_next     = '0;
          z_next     = {bus.angle_in[ANGLE_W-1], bus.angle_in};
          k_next     = '0;
          err_next   = out_of_range(bus.angle_in);
          state_next = ROT;
        end
      end
      ROT: begin
        if (bus.abort) begin
          k_next     = '0;
          state_next = IDLE;
        end else begin
          x_next = x_rot;
          y_next = y_rot;
          z_next = z_rot;
          if (k_reg == LAST_K) state_next = DONE;
          else                 k_next     = k_reg + 1'b1;
        end
      end
      DONE: begin
        // abort takes priority over a result handshake in the same cycle
        if (bus.abort || bus.out_ready) begin
          k_next     = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.lut_k     = k_reg;
  assign bus.cos_out   = x_reg;
  assign bus.sin_out   = y_reg;
  assign bus.z_res     = z_reg;
  assign bus.range_err = err_reg && (state_reg == DONE);
endmodule
